// File: rtl/app_ram_if.sv
// CPU memory-bus view of the application RAM: chip select, byte strobes,
// word address and data, plus the registered ready strobe.
interface app_ram_if;
  logic        cs;
  logic [3:0]  we;
  logic [14:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output cs,
    output we,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  cs,
    input  we,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/app_ram.sv
// 128 KiB application RAM: 32768 x 32 bits held in four 16384 x 16 banks
// (two pairs selected by address[14]), byte-masked writes, one-cycle reads.
module app_ram (
  input  logic      clk,
  input  logic      reset_n,
  app_ram_if.slave  bus
);

  logic [13:0]       row;
  logic              sel_hi;
  logic [1:0]        pair_sel;
  logic              wr_en;
  logic              rd_en;
  logic [3:0][3:0]   nib_we;
  logic [3:0][15:0]  bank_rd;

  logic              ready_d, ready_q;
  logic              sel_d, sel_q;
  logic [1:0][31:0]  rd_pair_d, rd_pair_q;

  assign row      = bus.address[13:0];
  assign sel_hi   = bus.address[14];
  assign pair_sel = {sel_hi, ~sel_hi};
  // Writes are suppressed while reset is held so no lane changes under reset.
  assign wr_en    = bus.cs && (bus.we != 4'h0) && reset_n;
  assign rd_en    = bus.cs && (bus.we == 4'h0);

  // Per-bank nibble mask: each byte strobe covers two nibbles of its bank.
  always_comb begin
    nib_we = '0;
    if (wr_en) begin
      nib_we[0] = pair_sel[0] ? {{2{bus.we[1]}}, {2{bus.we[0]}}} : 4'h0;
      nib_we[1] = pair_sel[0] ? {{2{bus.we[3]}}, {2{bus.we[2]}}} : 4'h0;
      nib_we[2] = pair_sel[1] ? {{2{bus.we[1]}}, {2{bus.we[0]}}} : 4'h0;
      nib_we[3] = pair_sel[1] ? {{2{bus.we[3]}}, {2{bus.we[2]}}} : 4'h0;
    end else begin
      nib_we = '0;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    localparam int LANE = 16 * (b % 2);
    logic [15:0] mem [16384];

    // Bank storage: not reset, written nibble by nibble.
    always_ff @(posedge clk) begin
      if (nib_we[b][0]) mem[row][3:0]   <= bus.write_data[LANE +: 4];
      if (nib_we[b][1]) mem[row][7:4]   <= bus.write_data[LANE + 4 +: 4];
      if (nib_we[b][2]) mem[row][11:8]  <= bus.write_data[LANE + 8 +: 4];
      if (nib_we[b][3]) mem[row][15:12] <= bus.write_data[LANE + 12 +: 4];
    end

    assign bank_rd[b] = mem[row];
  end

  // Next-state for the ready strobe, bank-select copy and pair read registers.
  always_comb begin
    ready_d   = bus.cs;
    sel_d     = sel_q;
    rd_pair_d = rd_pair_q;
    if (rd_en) begin
      sel_d = sel_hi;
      if (sel_hi) begin
        rd_pair_d[1] = {bank_rd[3], bank_rd[2]};
      end else begin
        rd_pair_d[0] = {bank_rd[1], bank_rd[0]};
      end
    end else begin
      sel_d     = sel_q;
      rd_pair_d = rd_pair_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      sel_q     <= 1'b0;
      rd_pair_q <= '0;
    end else begin
      ready_q   <= ready_d;
      sel_q     <= sel_d;
      rd_pair_q <= rd_pair_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.read_data = sel_q ? rd_pair_q[1] : rd_pair_q[0];

endmodule

// File: tb/tb_app_ram.sv
// Randomized self-checking bench for app_ram against a word-level memory model.
module tb_app_ram;

  logic clk;
  logic reset_n;
  app_ram_if bus ();

  app_ram dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model [logic [14:0]];
  logic [31:0] last_rd;
  logic [14:0] pool [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle with cs high; outputs are checked on the following negedge.
  task automatic access(input logic [3:0] w, input logic [14:0] a, input logic [31:0] d);
    logic [31:0] exp;
    logic [31:0] cur;
    exp = model.exists(a) ? model[a] : 32'h0;
    bus.cs = 1'b1;
    bus.we = w;
    bus.address = a;
    bus.write_data = d;
    @(posedge clk);
    @(negedge clk);
    check_val("ready", {31'h0, bus.ready}, 32'h1);
    if (w == 4'h0) begin
      check_val("rdata", bus.read_data, exp);
      last_rd = exp;
    end else begin
      check_val("rdata_hold_wr", bus.read_data, last_rd);
      cur = exp;
      for (int i = 0; i < 4; i++)
        if (w[i]) cur[8*i +: 8] = d[8*i +: 8];
      model[a] = cur;
    end
  endtask

  task automatic idle();
    bus.cs = 1'b0;
    bus.we = 4'h0;
    @(posedge clk);
    @(negedge clk);
    check_val("ready_idle", {31'h0, bus.ready}, 32'h0);
    check_val("rdata_hold", bus.read_data, last_rd);
  endtask

  initial begin
    logic [3:0]  w;
    logic [14:0] a;
    logic [31:0] d;
    reset_n = 1'b0;
    bus.cs = 1'b0;
    bus.we = 4'h0;
    bus.address = 15'h0;
    bus.write_data = 32'h0;
    last_rd = 32'h0;

    // Reset held for five cycles, then released with cs low.
    repeat (5) begin
      @(negedge clk);
      check_val("rst_ready", {31'h0, bus.ready}, 32'h0);
      check_val("rst_rdata", bus.read_data, 32'h0);
    end
    reset_n = 1'b1;
    repeat (3) idle();

    // Full-word write/read.
    access(4'hF, 15'h0000, 32'hDEADBEEF); idle();
    access(4'h0, 15'h0000, 32'h0);        idle();
    check_val("full_word", last_rd, 32'hDEADBEEF);

    // Byte strobes.
    access(4'hF, 15'h0123, 32'h11223344); idle();
    access(4'b0101, 15'h0123, 32'hAABBCCDD); idle();
    access(4'h0, 15'h0123, 32'h0); idle();
    check_val("byte_strobe", last_rd, 32'h11BB33DD);

    // Bank select, no aliasing, top address.
    access(4'hF, 15'h0010, 32'h0000A5A5); idle();
    access(4'hF, 15'h4010, 32'h5A5A0000); idle();
    access(4'h0, 15'h0010, 32'h0); idle();
    access(4'h0, 15'h4010, 32'h0); idle();
    access(4'hF, 15'h7FFF, 32'h76543210); idle();
    access(4'hF, 15'h3FFF, 32'h89ABCDEF); idle();
    access(4'h0, 15'h7FFF, 32'h0); idle();
    access(4'h0, 15'h3FFF, 32'h0); idle();

    // Back-to-back: write, read same word, read another.
    access(4'hF, 15'h0006, 32'hCAFEF00D); idle();
    access(4'hF, 15'h0005, 32'h01020304);
    access(4'h0, 15'h0005, 32'h0);
    access(4'h0, 15'h0006, 32'h0);
    idle();

    // Random traffic over a small address pool, every word initialized first.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 15'($urandom);
      access(4'hF, pool[i], $urandom);
    end
    idle();
    for (int i = 0; i < 300; i++) begin
      a = pool[$urandom_range(0, 7)];
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d = $urandom;
      access(w, a, d);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    // Async reset mid-read, and writes attempted under reset are ignored.
    access(4'hF, 15'h2222, 32'h5EED1234); idle();
    access(4'h0, 15'h0123, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_ready", {31'h0, bus.ready}, 32'h0);
    check_val("arst_rdata", bus.read_data, 32'h0);
    last_rd = 32'h0;
    bus.cs = 1'b1;
    bus.we = 4'hF;
    bus.address = 15'h2222;
    bus.write_data = 32'hBADBAD00;
    repeat (3) @(negedge clk);
    check_val("arst_ready_held", {31'h0, bus.ready}, 32'h0);
    bus.cs = 1'b0;
    bus.we = 4'h0;
    reset_n = 1'b1;
    idle();
    access(4'h0, 15'h2222, 32'h0); idle();
    check_val("no_wr_in_rst", last_rd, 32'h5EED1234);
    access(4'h0, 15'h0123, 32'h0); idle();
    check_val("kept_after_rst", last_rd, 32'h11BB33DD);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
